// File: rtl/sp_pkg.sv
// ---------------------------------------------------------------------------
// sp_pkg
// Shared definitions for the scratchpad result writer: default geometry,
// helper functions that derive the matrix dimension and address widths
// from that geometry, and the write-back FSM state encoding.
// ---------------------------------------------------------------------------
package sp_pkg;

    // Default scratchpad geometry
    localparam int SP_NTARGETS_DEFAULT = 4;
    localparam int DATA_WIDTH_DEFAULT  = 32;
    localparam int BUS_WIDTH_DEFAULT   = 64;

    // A square result matrix holds as many rows as fit elements in one row
    function automatic int calc_max_dim(input int bus_width, input int data_width);
        return bus_width / data_width;
    endfunction

    // Scratchpad row address covers every row of every target
    function automatic int calc_aw(input int ntargets, input int max_dim);
        return (ntargets * max_dim > 1) ? $clog2(ntargets * max_dim) : 1;
    endfunction

    // Width of an index into n items, never narrower than one bit
    function automatic int calc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Dimension field must be able to hold MAX_DIM itself
    function automatic int calc_dim_w(input int max_dim);
        return $clog2(max_dim) + 1;
    endfunction

    localparam int MAX_DIM_DEFAULT = calc_max_dim(BUS_WIDTH_DEFAULT, DATA_WIDTH_DEFAULT);
    localparam int AW_DEFAULT      = calc_aw(SP_NTARGETS_DEFAULT, MAX_DIM_DEFAULT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } sp_state_e;

endpackage

// File: rtl/sp_result_writer_if.sv
// ---------------------------------------------------------------------------
// sp_result_writer_if
// Result hand-off bundle between the matmul core (master) and the
// result writer (slave).
//   res_valid_i   master->slave  result matrix available
//   res_ready_o   slave->master  writer can accept a matrix
//   res_matrix_i  master->slave  MAX_DIM rows of BUS_WIDTH bits, row 0 lowest
//   res_target_i  master->slave  destination scratchpad target
//   res_dim_i     master->slave  active dimension (0 or >MAX_DIM = full size)
// Signal suffixes are from the writer's point of view.
// ---------------------------------------------------------------------------
interface sp_result_writer_if
    import sp_pkg::*;
#(
    parameter int SP_NTARGETS = SP_NTARGETS_DEFAULT,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int BUS_WIDTH   = BUS_WIDTH_DEFAULT
) ();

    localparam int MAX_DIM = calc_max_dim(BUS_WIDTH, DATA_WIDTH);
    localparam int TW      = calc_idx_w(SP_NTARGETS);
    localparam int DIMW    = calc_dim_w(MAX_DIM);

    logic                         res_valid_i;
    logic                         res_ready_o;
    logic [MAX_DIM*BUS_WIDTH-1:0] res_matrix_i;
    logic [TW-1:0]                res_target_i;
    logic [DIMW-1:0]              res_dim_i;

    modport master (
        output res_valid_i,
        output res_matrix_i,
        output res_target_i,
        output res_dim_i,
        input  res_ready_o
    );

    modport slave (
        input  res_valid_i,
        input  res_matrix_i,
        input  res_target_i,
        input  res_dim_i,
        output res_ready_o
    );

endinterface

// File: rtl/sp_row_mask.sv
// ---------------------------------------------------------------------------
// sp_row_mask
// Combinational zeroing of one result row so that only the active n x n
// corner of the matrix reaches the scratchpad.
//   row_i  raw row from the latched matrix
//   dim_i  active dimension n (already clamped to 1..MAX_DIM)
//   idx_i  index of this row within the matrix
//   row_o  row with element c zeroed when c >= n, all zero when idx >= n
// ---------------------------------------------------------------------------
module sp_row_mask
    import sp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int BUS_WIDTH  = BUS_WIDTH_DEFAULT,
    parameter int DIMW       = calc_dim_w(calc_max_dim(BUS_WIDTH_DEFAULT, DATA_WIDTH_DEFAULT)),
    parameter int RW         = calc_idx_w(calc_max_dim(BUS_WIDTH_DEFAULT, DATA_WIDTH_DEFAULT))
) (
    input  logic [BUS_WIDTH-1:0] row_i,
    input  logic [DIMW-1:0]      dim_i,
    input  logic [RW-1:0]        idx_i,
    output logic [BUS_WIDTH-1:0] row_o
);

    localparam int MAX_DIM = calc_max_dim(BUS_WIDTH, DATA_WIDTH);

    // Copy an element only when both its row and its column lie inside n
    always_comb begin
        row_o = '0;
        if (DIMW'(idx_i) < dim_i) begin
            for (int c = 0; c < MAX_DIM; c++) begin
                if (DIMW'(c) < dim_i) begin
                    row_o[c*DATA_WIDTH +: DATA_WIDTH] = row_i[c*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/sp_result_writer.sv
// ---------------------------------------------------------------------------
// sp_result_writer
// Write-back stage in front of the scratchpad. Takes one result matrix per
// handshake, then writes all MAX_DIM rows to the chosen target, one row per
// cycle, zeroing everything outside the active dimension.
//   clk_i      clock, rising edge
//   rst_i      asynchronous reset, active-high
//   res_if     result hand-off (slave side)
//   sp_we_o    scratchpad write enable
//   sp_addr_o  scratchpad row address = target*MAX_DIM + row
//   sp_data_o  masked row data
//   busy_o     transfer in progress (WRITE or DONE)
//   done_o     one-cycle pulse after the last row
// ---------------------------------------------------------------------------
module sp_result_writer
    import sp_pkg::*;
#(
    parameter int SP_NTARGETS = SP_NTARGETS_DEFAULT,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int BUS_WIDTH   = BUS_WIDTH_DEFAULT,
    localparam int MAX_DIM    = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
    localparam int AW         = calc_aw(SP_NTARGETS, MAX_DIM)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    sp_result_writer_if.slave    res_if,
    output logic                 sp_we_o,
    output logic [AW-1:0]        sp_addr_o,
    output logic [BUS_WIDTH-1:0] sp_data_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int TW   = calc_idx_w(SP_NTARGETS);
    localparam int DIMW = calc_dim_w(MAX_DIM);
    localparam int RW   = calc_idx_w(MAX_DIM);

    sp_state_e                    state_q;
    logic [MAX_DIM*BUS_WIDTH-1:0] matrix_q;
    logic [TW-1:0]                target_q;
    logic [DIMW-1:0]              dim_q;
    logic [RW-1:0]                row_q;
    logic [RW-1:0]                row_d;
    logic                         ready_q;
    logic                         we_q;
    logic                         busy_q;
    logic                         done_q;

    logic [DIMW-1:0]              dim_clamped;
    logic                         accept;
    logic                         last_row;
    logic [BUS_WIDTH-1:0]         row_raw;
    logic [BUS_WIDTH-1:0]         row_masked;

    // A dimension of 0 or anything larger than the matrix means full size
    always_comb begin
        dim_clamped = res_if.res_dim_i;
        if (res_if.res_dim_i == '0 || res_if.res_dim_i > DIMW'(MAX_DIM)) begin
            dim_clamped = DIMW'(MAX_DIM);
        end
    end

    // ready_q mirrors the IDLE state, so the handshake never looks at inputs
    // combinationally on its way to an output
    assign accept   = ready_q & res_if.res_valid_i;
    assign row_d    = row_q + RW'(1);
    assign last_row = (row_q == RW'(MAX_DIM - 1));
    assign row_raw  = matrix_q[row_q*BUS_WIDTH +: BUS_WIDTH];

    sp_row_mask #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH),
        .DIMW       (DIMW),
        .RW         (RW)
    ) u_row_mask (
        .row_i (row_raw),
        .dim_i (dim_q),
        .idx_i (row_q),
        .row_o (row_masked)
    );

    // Write-back FSM together with its latches, row counter and registered
    // status flags. Flags are set on the edge that enters each state, so
    // they always agree with state_q; a mid-transfer reset simply drops
    // everything, leaving earlier rows in the scratchpad and never pulsing done.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            matrix_q <= '0;
            target_q <= '0;
            dim_q    <= '0;
            row_q    <= '0;
            ready_q  <= 1'b1;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        matrix_q <= res_if.res_matrix_i;
                        target_q <= res_if.res_target_i;
                        dim_q    <= dim_clamped;
                        row_q    <= '0;
                        state_q  <= WRITE;
                        ready_q  <= 1'b0;
                        we_q     <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                WRITE: begin
                    row_q <= row_d;
                    if (last_row) begin
                        state_q <= DONE;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Address and data are only driven while writing; otherwise the bus idles at zero
    assign sp_we_o   = we_q;
    assign sp_addr_o = we_q ? (AW'(target_q) * AW'(MAX_DIM) + AW'(row_q)) : '0;
    assign sp_data_o = we_q ? row_masked : '0;

    assign res_if.res_ready_o = ready_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;

endmodule

// File: tb/tb_sp_result_writer.sv
// ---------------------------------------------------------------------------
// tb_sp_result_writer
// Self-checking bench: directed vector table, hand-written corner sequences
// and a randomized run against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_sp_result_writer;
    import sp_pkg::*;

    localparam int NT   = 4;
    localparam int DW   = 32;
    localparam int BW   = 64;
    localparam int MD   = BW / DW;
    localparam int AWID = 3;

    typedef struct {
        logic [MD*BW-1:0] mat;
        logic [1:0]       tgt;
        logic [1:0]       dim;
        logic [AWID-1:0]  a0;
        logic [BW-1:0]    d0;
        logic [AWID-1:0]  a1;
        logic [BW-1:0]    d1;
    } vec_t;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            sp_we_o;
    logic [AWID-1:0] sp_addr_o;
    logic [BW-1:0]   sp_data_o;
    logic            busy_o;
    logic            done_o;

    int testsRun    = 0;
    int testsFailed = 0;

    vec_t vecs[6];

    sp_result_writer_if #(.SP_NTARGETS(NT), .DATA_WIDTH(DW), .BUS_WIDTH(BW)) resIf ();

    sp_result_writer #(.SP_NTARGETS(NT), .DATA_WIDTH(DW), .BUS_WIDTH(BW)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .res_if    (resIf),
        .sp_we_o   (sp_we_o),
        .sp_addr_o (sp_addr_o),
        .sp_data_o (sp_data_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    // Free-running clock, 10 time units per period
    always #5 clk_i = ~clk_i;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge, where outputs are sampled
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one matrix for a single accept edge; returns in cycle k+1
    task automatic applyStimulus(input logic [MD*BW-1:0] mat, input logic [1:0] tgt, input logic [1:0] dim);
        resIf.res_valid_i  = 1'b1;
        resIf.res_matrix_i = mat;
        resIf.res_target_i = tgt;
        resIf.res_dim_i    = dim;
        tick();
        resIf.res_valid_i  = 1'b0;
        resIf.res_matrix_i = {$urandom, $urandom, $urandom, $urandom};
        resIf.res_target_i = 2'($urandom);
        resIf.res_dim_i    = 2'($urandom);
    endtask

    // Drive one table vector and check the full k+1..k+4 timeline
    task automatic runVector(input vec_t v, input string tag);
        applyStimulus(v.mat, v.tgt, v.dim);
        checkOutput({tag, " we0"},    64'(sp_we_o),   64'd1);
        checkOutput({tag, " addr0"},  64'(sp_addr_o), 64'(v.a0));
        checkOutput({tag, " data0"},  sp_data_o,      v.d0);
        checkOutput({tag, " ready0"}, 64'(resIf.res_ready_o), 64'd0);
        checkOutput({tag, " busy0"},  64'(busy_o),    64'd1);
        tick();
        checkOutput({tag, " we1"},    64'(sp_we_o),   64'd1);
        checkOutput({tag, " addr1"},  64'(sp_addr_o), 64'(v.a1));
        checkOutput({tag, " data1"},  sp_data_o,      v.d1);
        tick();
        checkOutput({tag, " done"},   64'(done_o),    64'd1);
        checkOutput({tag, " weOff"},  64'(sp_we_o),   64'd0);
        checkOutput({tag, " addrOff"}, 64'(sp_addr_o), 64'd0);
        checkOutput({tag, " dataOff"}, sp_data_o,     64'd0);
        tick();
        checkOutput({tag, " readyBack"}, 64'(resIf.res_ready_o), 64'd1);
        checkOutput({tag, " doneOff"},   64'(done_o), 64'd0);
        checkOutput({tag, " busyOff"},   64'(busy_o), 64'd0);
    endtask

    // Reference rule: element (r,c) survives only when both r and c are below n
    function automatic logic [BW-1:0] modelRow(input logic [MD*BW-1:0] mat, input int r, input int dim);
        int n;
        logic [BW-1:0] row;
        n   = (dim == 0 || dim > MD) ? MD : dim;
        row = '0;
        for (int c = 0; c < MD; c++) begin
            if (r < n && c < n) row[c*DW +: DW] = mat[r*BW + c*DW +: DW];
        end
        return row;
    endfunction

    // Main test sequence
    initial begin
        logic [MD*BW-1:0] base;
        logic [MD*BW-1:0] mat2;
        int t, wrStart, doneCycle, nextFree, expTgt;
        logic [BW-1:0] expRows[MD];
        logic [MD*BW-1:0] rm;
        logic rv;
        logic [1:0] rt, rd;

        base = {64'h0000_0004_0000_0003, 64'h0000_0002_0000_0001};
        mat2 = {64'hDEAD_BEEF_CAFE_F00D, 64'h1234_5678_9ABC_DEF0};

        vecs[0] = '{base, 2'd1, 2'd2, 3'd2, 64'h0000_0002_0000_0001, 3'd3, 64'h0000_0004_0000_0003};
        vecs[1] = '{base, 2'd3, 2'd1, 3'd6, 64'h0000_0000_0000_0001, 3'd7, 64'h0};
        vecs[2] = '{base, 2'd0, 2'd0, 3'd0, 64'h0000_0002_0000_0001, 3'd1, 64'h0000_0004_0000_0003};
        vecs[3] = '{mat2, 2'd2, 2'd3, 3'd4, 64'h1234_5678_9ABC_DEF0, 3'd5, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[4] = '{mat2, 2'd2, 2'd1, 3'd4, 64'h0000_0000_9ABC_DEF0, 3'd5, 64'h0};
        vecs[5] = '{mat2, 2'd1, 2'd2, 3'd2, 64'h1234_5678_9ABC_DEF0, 3'd3, 64'hDEAD_BEEF_CAFE_F00D};

        resIf.res_valid_i  = 1'b0;
        resIf.res_matrix_i = '0;
        resIf.res_target_i = '0;
        resIf.res_dim_i    = '0;
        rst_i = 1'b1;
        #1;
        checkOutput("rst we",    64'(sp_we_o),   64'd0);
        checkOutput("rst ready", 64'(resIf.res_ready_o), 64'd1);
        #20;
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        checkOutput("post-rst ready", 64'(resIf.res_ready_o), 64'd1);
        checkOutput("post-rst addr",  64'(sp_addr_o), 64'd0);
        checkOutput("post-rst data",  sp_data_o,      64'd0);
        checkOutput("post-rst busy",  64'(busy_o),    64'd0);
        checkOutput("post-rst done",  64'(done_o),    64'd0);

        for (int i = 0; i < 6; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back: valid held high; second matrix offered during WRITE
        resIf.res_valid_i  = 1'b1;
        resIf.res_matrix_i = base;
        resIf.res_target_i = 2'd0;
        resIf.res_dim_i    = 2'd2;
        tick();
        resIf.res_matrix_i = mat2;
        resIf.res_target_i = 2'd2;
        checkOutput("b2b addr0", 64'(sp_addr_o), 64'd0);
        checkOutput("b2b data0", sp_data_o, 64'h0000_0002_0000_0001);
        tick();
        checkOutput("b2b addr1", 64'(sp_addr_o), 64'd1);
        checkOutput("b2b data1", sp_data_o, 64'h0000_0004_0000_0003);
        tick();
        checkOutput("b2b done", 64'(done_o), 64'd1);
        tick();
        checkOutput("b2b ready k+4", 64'(resIf.res_ready_o), 64'd1);
        checkOutput("b2b we k+4",    64'(sp_we_o), 64'd0);
        tick();
        resIf.res_valid_i = 1'b0;
        checkOutput("b2b addr4", 64'(sp_addr_o), 64'd4);
        checkOutput("b2b data4", sp_data_o, 64'h1234_5678_9ABC_DEF0);
        tick();
        checkOutput("b2b addr5", 64'(sp_addr_o), 64'd5);
        checkOutput("b2b data5", sp_data_o, 64'hDEAD_BEEF_CAFE_F00D);
        tick();
        checkOutput("b2b done2", 64'(done_o), 64'd1);
        tick();
        tick();
        checkOutput("b2b no third", 64'(sp_we_o), 64'd0);

        // Inputs wiggled during WRITE must not disturb the latched transfer
        applyStimulus(base, 2'd3, 2'd1);
        resIf.res_valid_i  = 1'b1;
        resIf.res_matrix_i = mat2;
        resIf.res_target_i = 2'd0;
        resIf.res_dim_i    = 2'd2;
        checkOutput("wig addr0", 64'(sp_addr_o), 64'd6);
        checkOutput("wig data0", sp_data_o, 64'h0000_0000_0000_0001);
        tick();
        resIf.res_valid_i = 1'b0;
        checkOutput("wig addr1", 64'(sp_addr_o), 64'd7);
        checkOutput("wig data1", sp_data_o, 64'h0);
        tick();
        checkOutput("wig done", 64'(done_o), 64'd1);
        tick();
        tick();
        checkOutput("wig no extra", 64'(sp_we_o), 64'd0);
        checkOutput("wig ready",    64'(resIf.res_ready_o), 64'd1);

        // Reset mid-transfer
        applyStimulus(base, 2'd1, 2'd2);
        checkOutput("mid-rst we before", 64'(sp_we_o), 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("mid-rst we", 64'(sp_we_o), 64'd0);
        checkOutput("mid-rst busy", 64'(busy_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("mid-rst no done %0d", i), 64'(done_o), 64'd0);
            checkOutput($sformatf("mid-rst ready %0d", i), 64'(resIf.res_ready_o), 64'd1);
        end
        runVector(vecs[1], "after-rst");

        // Randomized run against a transaction-level model keyed by cycle number
        t = 0; wrStart = -100; doneCycle = -100; nextFree = 0; expTgt = 0;
        for (int i = 0; i < MD; i++) expRows[i] = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (t >= wrStart && t < wrStart + MD) begin
                checkOutput("rnd we",   64'(sp_we_o),   64'd1);
                checkOutput("rnd addr", 64'(sp_addr_o), 64'(expTgt * MD + (t - wrStart)));
                checkOutput("rnd data", sp_data_o,      expRows[t - wrStart]);
            end else begin
                checkOutput("rnd we idle", 64'(sp_we_o), 64'd0);
            end
            checkOutput("rnd done",  64'(done_o), 64'(t == doneCycle));
            checkOutput("rnd ready", 64'(resIf.res_ready_o), 64'(t >= nextFree));

            rv = ($urandom_range(0, 2) != 0);
            rm = {$urandom, $urandom, $urandom, $urandom};
            rt = 2'($urandom_range(0, 3));
            rd = 2'($urandom_range(0, 3));
            resIf.res_valid_i  = rv;
            resIf.res_matrix_i = rm;
            resIf.res_target_i = rt;
            resIf.res_dim_i    = rd;
            if (rv && t >= nextFree) begin
                for (int r = 0; r < MD; r++) expRows[r] = modelRow(rm, r, int'(rd));
                expTgt    = int'(rt);
                wrStart   = t + 1;
                doneCycle = t + MD + 1;
                nextFree  = t + MD + 2;
            end
            tick();
            t++;
        end
        resIf.res_valid_i = 1'b0;
        repeat (5) tick();
        checkOutput("final ready", 64'(resIf.res_ready_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
